// File: rtl/spi_slave_regif.sv
// SPI mode-0 target: 16-bit header (RNW + address) followed by DATA_W-bit words -> register strobes.
// Optional macro SPI_ADDR_AUTOINC_EN: reg_addr advances by one after every data word.
module spi_slave_regif #(
  parameter int ADDR_W   = 8,
  parameter int DATA_W   = 32,
  parameter int SYNC_STG = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              spi_sclk,
  input  logic              spi_cs_n,
  input  logic              spi_mosi,
  output logic              spi_miso,
  output logic [ADDR_W-1:0] reg_addr,
  output logic [DATA_W-1:0] reg_wdata,
  output logic              reg_wr_en,
  output logic              reg_rd_en,
  input  logic [DATA_W-1:0] reg_rdata,
  output logic              frame_err
);

  localparam int HDR_W = 16;
  localparam int CNT_W = $clog2((DATA_W > HDR_W ? DATA_W : HDR_W) + 1);

`ifdef SPI_ADDR_AUTOINC_EN
  localparam logic [ADDR_W-1:0] ADDR_INC = ADDR_W'(1);
`else
  localparam logic [ADDR_W-1:0] ADDR_INC = '0;
`endif

  typedef enum logic [1:0] {IDLE, HDR, WR, RD} state_t;

  state_t              state, state_nxt;
  logic [SYNC_STG-1:0] sclk_sync, cs_sync, mosi_sync;
  logic                sclk_prev;
  logic                sclk_s, cs_s, cs_prev, mosi_s;
  logic                sclk_rise, sclk_fall, cs_fall;
  logic [CNT_W-1:0]    bit_cnt;
  logic [HDR_W-2:0]    hdr_sh;
  logic [HDR_W-1:0]    hdr_full;
  logic [DATA_W-2:0]   rx_sh;
  logic [DATA_W-1:0]   tx_sh;
  logic                rd_cap;
  logic                hdr_done, word_done;

  assign sclk_s    = sclk_sync[SYNC_STG-1];
  assign cs_s      = cs_sync[SYNC_STG-1];
  assign mosi_s    = mosi_sync[SYNC_STG-1];
  assign sclk_rise = sclk_s & ~sclk_prev;
  assign sclk_fall = ~sclk_s & sclk_prev;
  assign cs_fall   = cs_prev & ~cs_s;
  assign hdr_full  = {hdr_sh, mosi_s};

  // NOTE: every clocked block uses non-blocking (<=) assignments so all flops update
  // together from pre-edge values; blocking (=) here would create ordering-dependent races.
  // CS syncs reset to "selected" so a CS held low through reset never looks like a new falling edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_sync <= '0;
      cs_sync   <= '0;
      mosi_sync <= '0;
      sclk_prev <= 1'b0;
      cs_prev   <= 1'b0;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STG-2:0], spi_sclk};
      cs_sync   <= {cs_sync[SYNC_STG-2:0], spi_cs_n};
      mosi_sync <= {mosi_sync[SYNC_STG-2:0], spi_mosi};
      sclk_prev <= sclk_s;
      cs_prev   <= cs_s;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // NOTE: combinational blocks assign a default to every output first; a path that
  // leaves a variable unassigned would otherwise infer a latch.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (cs_fall) state_nxt = HDR;
      HDR: begin
        if (cs_s)          state_nxt = IDLE;
        else if (hdr_done) state_nxt = hdr_full[HDR_W-1] ? RD : WR;
      end
      WR, RD: if (cs_s) state_nxt = IDLE;
    endcase
  end

  always_comb begin
    hdr_done  = 1'b0;
    word_done = 1'b0;
    spi_miso  = 1'b0;
    if (!cs_s && sclk_rise) begin
      hdr_done  = (state == HDR) && (bit_cnt == CNT_W'(HDR_W - 1));
      word_done = (state == WR || state == RD) && (bit_cnt == CNT_W'(DATA_W - 1));
    end
    if (state == RD) spi_miso = tx_sh[DATA_W-1];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt   <= '0;
      hdr_sh    <= '0;
      rx_sh     <= '0;
      tx_sh     <= '0;
      rd_cap    <= 1'b0;
      reg_addr  <= '0;
      reg_wdata <= '0;
      reg_wr_en <= 1'b0;
      reg_rd_en <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      reg_wr_en <= 1'b0;
      reg_rd_en <= 1'b0;
      rd_cap    <= reg_rd_en;
      frame_err <= (state != IDLE) && cs_s && (bit_cnt != '0);
      if (reg_wr_en) reg_addr <= reg_addr + ADDR_INC;

      if (state == IDLE || cs_s) begin
        bit_cnt <= '0;
      end else if (sclk_rise) begin
        if (state == HDR) begin
          hdr_sh <= hdr_full[HDR_W-2:0];
          if (hdr_done) begin
            bit_cnt   <= '0;
            reg_addr  <= hdr_full[ADDR_W-1:0];
            reg_rd_en <= hdr_full[HDR_W-1];
          end else begin
            bit_cnt <= bit_cnt + CNT_W'(1);
          end
        end else begin
          rx_sh <= {rx_sh[DATA_W-3:0], mosi_s};
          if (word_done) begin
            bit_cnt <= '0;
            if (state == WR) begin
              reg_wdata <= {rx_sh, mosi_s};
              reg_wr_en <= 1'b1;
            end else begin
              reg_addr  <= reg_addr + ADDR_INC;
              reg_rd_en <= 1'b1;
            end
          end else begin
            bit_cnt <= bit_cnt + CNT_W'(1);
          end
        end
      end else if (sclk_fall && state == RD && bit_cnt != '0) begin
        // The fall right after a word boundary must not shift: the prefetched MSB is still pending.
        tx_sh <= {tx_sh[DATA_W-2:0], 1'b0};
      end

      if (rd_cap) tx_sh <= reg_rdata;
    end
  end

endmodule

// File: tb/tb_spi_slave_regif.sv
// Self-checking bench for spi_slave_regif: directed vector table, reset-abort sequence, random frames vs model.
module tb_spi_slave_regif;

`ifdef SPI_ADDR_AUTOINC_EN
  localparam int INC = 1;
`else
  localparam int INC = 0;
`endif
  localparam int HALF = 6;  // clk cycles per SCLK half period

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        spi_sclk = 1'b0;
  logic        spi_cs_n = 1'b1;
  logic        spi_mosi = 1'b0;
  logic        spi_miso;
  logic [7:0]  reg_addr;
  logic [31:0] reg_wdata;
  logic        reg_wr_en;
  logic        reg_rd_en;
  logic [31:0] reg_rdata = 32'h0;
  logic        frame_err;

  spi_slave_regif dut (
    .clk       (clk),
    .rst       (rst),
    .spi_sclk  (spi_sclk),
    .spi_cs_n  (spi_cs_n),
    .spi_mosi  (spi_mosi),
    .spi_miso  (spi_miso),
    .reg_addr  (reg_addr),
    .reg_wdata (reg_wdata),
    .reg_wr_en (reg_wr_en),
    .reg_rd_en (reg_rd_en),
    .reg_rdata (reg_rdata),
    .frame_err (frame_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int err_cnt  = 0;
  int overlap_cnt = 0;

  logic [31:0] mem [256];
  logic [31:0] wr_addr_q[$], wr_data_q[$], rd_addr_q[$], miso_q[$], tx_q[$];
  logic [31:0] tail_val;

  // Register-bus responder: read data appears the cycle after reg_rd_en.
  always @(negedge clk) begin
    if (!rst) begin
      if (reg_wr_en) begin
        wr_addr_q.push_back({24'h0, reg_addr});
        wr_data_q.push_back(reg_wdata);
      end
      if (reg_rd_en) begin
        rd_addr_q.push_back({24'h0, reg_addr});
        reg_rdata = mem[reg_addr];
      end
      if (reg_wr_en && reg_rd_en) overlap_cnt++;
      if (frame_err) err_cnt++;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else n_pass++;
  endtask

  function automatic logic [63:0] pick(input logic [31:0] q[$], input int i);
    if (i < q.size()) return {32'h0, q[i]};
    return '1;
  endfunction

  task automatic clear_obs();
    wr_addr_q.delete();
    wr_data_q.delete();
    rd_addr_q.delete();
    miso_q.delete();
    err_cnt = 0;
  endtask

  // One SCLK period, mode 0: MOSI set while SCLK low, MISO sampled as SCLK rises.
  task automatic spi_bit(input logic b, output logic m);
    spi_mosi = b;
    repeat (HALF) @(negedge clk);
    m = spi_miso;
    spi_sclk = 1'b1;
    repeat (HALF) @(negedge clk);
    spi_sclk = 1'b0;
  endtask

  task automatic run_frame(input logic [15:0] hdr, input int hb, input int tb);
    logic        m;
    logic [31:0] mw;
    clear_obs();
    mw = '0;
    spi_cs_n = 1'b0;
    repeat (HALF) @(negedge clk);
    for (int i = 0; i < hb; i++) spi_bit(hdr[15-i], m);
    if (hb == 16) begin
      foreach (tx_q[w]) begin
        for (int i = 0; i < 32; i++) begin
          spi_bit(hdr[15] ? 1'b0 : tx_q[w][31-i], m);
          mw = {mw[30:0], m};
        end
        miso_q.push_back(mw);
      end
      for (int i = 0; i < tb; i++) spi_bit(tail_val[31-i], m);
    end
    repeat (HALF) @(negedge clk);
    spi_cs_n = 1'b1;
    repeat (4*HALF) @(negedge clk);
  endtask

  typedef struct {
    logic [15:0] hdr;
    int          hb;
    int          nw;
    logic [31:0] w0, w1;
    int          tb;
    logic [31:0] tv;
    int          exp_n;
    logic [7:0]  exp_a0, exp_a1;
    logic [31:0] exp_d0, exp_d1;
    int          exp_err;
  } vec_t;

  localparam int NV = 7;
  vec_t vecs [NV];

  initial begin
    vec_t        v;
    logic        is_rd, m, rnw;
    logic [31:0] aq[$], dq[$];
    logic [15:0] hdr;
    logic [7:0]  a, ea;
    int          hb, nw, tb, exp_wr, exp_rd, exp_err;

    for (int i = 0; i < 256; i++) mem[i] = $urandom;
    mem[8'h34] = 32'hcafef00d;

    vecs[0] = '{16'h0012, 16, 1, 32'h1745ad08, 32'h0, 0, 32'h0,
                1, 8'h12, 8'h00, 32'h1745ad08, 32'h0, 0};
    vecs[1] = '{16'h8034, 16, 1, 32'h0, 32'h0, 0, 32'h0,
                2, 8'h34, 8'(8'h34 + INC), 32'hcafef00d, 32'h0, 0};
    vecs[2] = '{16'h00ff, 16, 2, 32'h1, 32'h2, 0, 32'h0,
                2, 8'hff, 8'(8'hff + INC), 32'h1, 32'h2, 0};
    vecs[3] = '{16'h0020, 16, 1, 32'h11111111, 32'h0, 16, 32'hdead0000,
                1, 8'h20, 8'h00, 32'h11111111, 32'h0, 1};
    vecs[4] = '{16'h0040, 9, 0, 32'h0, 32'h0, 0, 32'h0,
                0, 8'h00, 8'h00, 32'h0, 32'h0, 1};
    vecs[5] = '{16'h0077, 16, 0, 32'h0, 32'h0, 0, 32'h0,
                0, 8'h00, 8'h00, 32'h0, 32'h0, 0};
    vecs[6] = '{16'h80ff, 16, 2, 32'h0, 32'h0, 0, 32'h0,
                3, 8'hff, 8'(8'hff + INC), mem[8'hff], mem[8'(8'hff + INC)], 0};

    repeat (5) @(negedge clk);
    check("rst_miso",      64'(spi_miso),  64'h0);
    check("rst_reg_addr",  64'(reg_addr),  64'h0);
    check("rst_reg_wdata", 64'(reg_wdata), 64'h0);
    check("rst_wr_en",     64'(reg_wr_en), 64'h0);
    check("rst_rd_en",     64'(reg_rd_en), 64'h0);
    check("rst_frame_err", 64'(frame_err), 64'h0);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    for (int k = 0; k < NV; k++) begin
      v = vecs[k];
      tx_q.delete();
      if (v.nw > 0) tx_q.push_back(v.w0);
      if (v.nw > 1) tx_q.push_back(v.w1);
      tail_val = v.tv;
      run_frame(v.hdr, v.hb, v.tb);
      is_rd = v.hdr[15];
      if (is_rd) begin
        aq = rd_addr_q; dq = miso_q;
        check($sformatf("v%0d_n_wr", k), 64'(wr_addr_q.size()), 64'h0);
      end else begin
        aq = wr_addr_q; dq = wr_data_q;
        check($sformatf("v%0d_n_rd", k), 64'(rd_addr_q.size()), 64'h0);
      end
      check($sformatf("v%0d_n_strobe", k), 64'(aq.size()), 64'(v.exp_n));
      for (int i = 0; i < 2; i++) begin
        if (i < v.exp_n)
          check($sformatf("v%0d_addr%0d", k, i), pick(aq, i), 64'(i == 0 ? v.exp_a0 : v.exp_a1));
        if (i < v.nw)
          check($sformatf("v%0d_data%0d", k, i), pick(dq, i), 64'(i == 0 ? v.exp_d0 : v.exp_d1));
      end
      check($sformatf("v%0d_frame_err", k), 64'(err_cnt), 64'(v.exp_err));
    end

    // Reset in the middle of a header; the rest of that frame must be ignored.
    clear_obs();
    hdr = 16'h0005;
    spi_cs_n = 1'b0;
    repeat (HALF) @(negedge clk);
    for (int i = 0; i < 8; i++) spi_bit(hdr[15-i], m);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    for (int i = 8; i < 16; i++) spi_bit(hdr[15-i], m);
    for (int i = 0; i < 32; i++) spi_bit(1'b1, m);
    repeat (HALF) @(negedge clk);
    spi_cs_n = 1'b1;
    repeat (4*HALF) @(negedge clk);
    check("abort_n_wr", 64'(wr_addr_q.size()), 64'h0);
    check("abort_n_rd", 64'(rd_addr_q.size()), 64'h0);
    check("abort_frame_err", 64'(err_cnt), 64'h0);
    tx_q.delete();
    tx_q.push_back(32'h5);
    run_frame(16'h0005, 16, 0);
    check("after_rst_n_wr", 64'(wr_addr_q.size()), 64'h1);
    check("after_rst_addr", pick(wr_addr_q, 0), 64'h05);
    check("after_rst_data", pick(wr_data_q, 0), 64'h5);
    check("after_rst_frame_err", 64'(err_cnt), 64'h0);

    // Random frames against the frame-level model.
    for (int f = 0; f < 16; f++) begin
      rnw = 1'($urandom_range(0, 1));
      a   = ($urandom_range(0, 3) == 0) ? 8'hff : 8'($urandom);
      hdr = {rnw, 7'($urandom), a};
      hb  = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 15)) : 16;
      nw  = $urandom_range(0, 2);
      tb  = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 31)) : 0;
      tx_q.delete();
      for (int i = 0; i < nw; i++) tx_q.push_back($urandom);
      tail_val = $urandom;
      run_frame(hdr, hb, tb);

      exp_wr  = (hb == 16 && !rnw) ? nw : 0;
      exp_rd  = (hb == 16 && rnw) ? nw + 1 : 0;
      exp_err = (hb < 16 || tb > 0) ? 1 : 0;
      check($sformatf("r%0d_n_wr", f), 64'(wr_addr_q.size()), 64'(exp_wr));
      check($sformatf("r%0d_n_rd", f), 64'(rd_addr_q.size()), 64'(exp_rd));
      check($sformatf("r%0d_frame_err", f), 64'(err_cnt), 64'(exp_err));
      for (int i = 0; i < exp_wr; i++) begin
        ea = 8'(int'(a) + i * INC);
        check($sformatf("r%0d_wr_addr%0d", f, i), pick(wr_addr_q, i), 64'(ea));
        check($sformatf("r%0d_wr_data%0d", f, i), pick(wr_data_q, i), 64'(tx_q[i]));
      end
      for (int i = 0; i < exp_rd; i++) begin
        ea = 8'(int'(a) + i * INC);
        check($sformatf("r%0d_rd_addr%0d", f, i), pick(rd_addr_q, i), 64'(ea));
        if (i < nw)
          check($sformatf("r%0d_miso%0d", f, i), pick(miso_q, i), 64'(mem[ea]));
      end
    end

    check("no_strobe_overlap", 64'(overlap_cnt), 64'h0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
